req_ack_window_checker: RTL and testbench
=========================================

# req_ack_window_checker

Synthesizable, multi-channel request/acknowledge latency checker: the hardware successor to our req/ack variable-delay property checks. For each of NUM_CH channels it detects a rising req, measures cycles to the next rising ack, and reports pass if the latency is in [MIN_DLY:MAX_DLY]; otherwise it reports fail. The result is usable on silicon and FPGA, not just in simulation. It sits beside any req/ack handshake as a passive monitor. It exposes per-channel verdict pulses, last latency, and saturating aggregate counters.

## Interface
- NUM_CH, 4, number of independent req/ack channels (≥1)
- MIN_DLY, 3, minimum legal latency in cycles (≥1)
- MAX_DLY, 6, maximum legal latency in cycles (≥MIN_DLY)
- CNT_W, 8, width of aggregate pass/fail counters
- RESTART_ON_REQ, 1, 1: new req rise during a pending check restarts it; 0: ignored
- DLY_W, $clog2(MAX_DLY+1), derived latency width (localparam)

- clk  in  1  sole clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; 0 freezes all channel state and counters
- req  in  NUM_CH  per-channel request
- ack  in  NUM_CH  per-channel acknowledge
- pass_o  out  NUM_CH  one-cycle pulse: check passed
- fail_o  out  NUM_CH  one-cycle pulse: check failed
- early_o  out  NUM_CH  qualifies fail_o: 1 = ack too early, 0 = timeout
- overlap_o  out  NUM_CH  one-cycle pulse: req rose while check pending
- busy_o  out  NUM_CH  channel in WAIT
- lat_o  out  NUM_CH*DLY_W  latency of last ack-terminated check, channel i in bits [i*DLY_W +: DLY_W]
- pass_cnt  out  CNT_W  total passes, saturating
- fail_cnt  out  CNT_W  total fails, saturating

## Operation
- Edge detect: req_q/ack_q registered each enabled edge; rise = x & ~x_q. Reset value of req_q/ack_q is 0, so a req held high through reset release counts as a rise on the first enabled edge.
- Per-channel FSM, states IDLE and WAIT:
  - IDLE: on a req rise → WAIT, d←0. An ack rise in IDLE is ignored.
  - WAIT: d←d+1 each enabled edge. The offset of an edge is its d value after increment.
  - Ack rise at offset d < MIN_DLY → fail, early=1, lat←d, → IDLE.
  - Ack rise at MIN_DLY ≤ d ≤ MAX_DLY → pass, lat←d, → IDLE.
  - No ack rise at d = MAX_DLY → fail, early=0, lat unchanged, → IDLE.
- An ack rise on the same edge as the triggering req rise (offset 0) is not counted.
- Req rise while in WAIT:
  - If a verdict also occurs on that edge, the verdict is issued first and a new check starts (WAIT, d←0). No overlap pulse.
  - Otherwise overlap_o pulses. With RESTART_ON_REQ=1 the check restarts with d←0 and no verdict for the old one. With RESTART_ON_REQ=0 the old check continues.
- Counters: pass_cnt is incremented by popcount of the channel passes on that edge, and fail_cnt likewise by popcount of fails. Each saturates at 2^CNT_W−1 and never wraps.
- en=0: no state, d, edge registers or counters change. Pulse outputs are 0.
- Reset: all outputs 0, all FSMs IDLE, d=0, lat_o=0, counters 0. Reset asserted mid-check discards the check with no verdict.

## Timing
- All outputs registered. A verdict decided at edge k is visible after edge k until edge k+1. Pulses last exactly one cycle.
- busy_o rises the cycle after the req-rise edge. It falls the cycle after the verdict edge, unless a restart keeps it high.
- Worst-case timeout verdict: MAX_DLY edges after the req-rise edge.
- No combinational path from inputs to outputs.

## Test plan
- Single channel, defaults: req rises, ack rises at offset 4 → pass_o[0] pulse, lat=4, pass_cnt=1.
- Ack at offset 2 → fail_o[0] with early_o[0]=1, lat=2. No ack by offset 6 → fail_o with early=0 at offset-6 edge+1, fail_cnt increments.
- Boundaries: ack at offset 3 and at offset 6 both pass; ack at offset 0 is ignored and the check then times out.
- Overlap:
  - RESTART_ON_REQ=1: req re-rises at offset 2 → overlap_o pulse, restart, and ack 4 cycles later passes with lat=4.
  - RESTART_ON_REQ=0: the same stimulus leaves the original check running and it times out.
- All 4 channels pass on the same edge → pass_cnt +4. With CNT_W=2, preload to 3 passes, then pass again → stays 3.
- rst pulsed asynchronously mid-WAIT → all outputs 0 immediately, no verdict. en=0 for 3 cycles mid-check → d frozen, and the verdict is delayed by 3 cycles.

Source files
------------

// File: rtl/req_ack_window_checker.sv
// Passive multi-channel req/ack latency monitor. Each channel times a rising req
// to the next rising ack and issues a pass/fail verdict against [MIN_DLY:MAX_DLY].
module req_ack_window_checker #(
  parameter int NUM_CH         = 4,
  parameter int MIN_DLY        = 3,
  parameter int MAX_DLY        = 6,
  parameter int CNT_W          = 8,
  parameter bit RESTART_ON_REQ = 1'b1,
  localparam int DLY_W         = $clog2(MAX_DLY + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       pass_o,
  output logic [NUM_CH-1:0]       fail_o,
  output logic [NUM_CH-1:0]       early_o,
  output logic [NUM_CH-1:0]       overlap_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH*DLY_W-1:0] lat_o,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [DLY_W-1:0] MIN_D = DLY_W'(MIN_DLY);
  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DLY);
  localparam int POP_W = $clog2(NUM_CH + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] ack_q;
  logic [NUM_CH-1:0] req_rise;
  logic [NUM_CH-1:0] ack_rise;

  state_t           state     [NUM_CH];
  state_t           state_nxt [NUM_CH];
  logic [DLY_W-1:0] d         [NUM_CH];
  logic [DLY_W-1:0] d_nxt     [NUM_CH];
  logic [DLY_W-1:0] d_inc     [NUM_CH];
  logic [DLY_W-1:0] lat       [NUM_CH];
  logic [DLY_W-1:0] lat_nxt   [NUM_CH];

  logic [NUM_CH-1:0] pass_nxt;
  logic [NUM_CH-1:0] fail_nxt;
  logic [NUM_CH-1:0] early_nxt;
  logic [NUM_CH-1:0] overlap_nxt;

  logic [POP_W-1:0] pass_pop;
  logic [POP_W-1:0] fail_pop;
  logic [SUM_W-1:0] pass_sum;
  logic [SUM_W-1:0] fail_sum;
  logic [CNT_W-1:0] pass_cnt_nxt;
  logic [CNT_W-1:0] fail_cnt_nxt;

  assign req_rise = req & ~req_q;
  assign ack_rise = ack & ~ack_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      d_inc[i] = d[i] + 1'b1;
    end
  end

  // A verdict and a new req rise on the same edge chain straight into a fresh check.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i]   = state[i];
      d_nxt[i]       = d[i];
      lat_nxt[i]     = lat[i];
      pass_nxt[i]    = 1'b0;
      fail_nxt[i]    = 1'b0;
      early_nxt[i]   = 1'b0;
      overlap_nxt[i] = 1'b0;
      case (state[i])
        IDLE: begin
          if (req_rise[i]) begin
            state_nxt[i] = WAIT;
            d_nxt[i]     = '0;
          end
        end
        WAIT: begin
          d_nxt[i] = d_inc[i];
          if (ack_rise[i]) begin
            lat_nxt[i]   = d_inc[i];
            state_nxt[i] = IDLE;
            if (d_inc[i] < MIN_D) begin
              fail_nxt[i]  = 1'b1;
              early_nxt[i] = 1'b1;
            end else begin
              pass_nxt[i] = 1'b1;
            end
          end else if (d_inc[i] >= MAX_D) begin
            fail_nxt[i]  = 1'b1;
            state_nxt[i] = IDLE;
          end
          if (req_rise[i]) begin
            if (pass_nxt[i] || fail_nxt[i]) begin
              state_nxt[i] = WAIT;
              d_nxt[i]     = '0;
            end else begin
              overlap_nxt[i] = 1'b1;
              if (RESTART_ON_REQ) begin
                d_nxt[i] = '0;
              end
            end
          end
        end
        default: begin
          state_nxt[i] = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pass_pop = '0;
    fail_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_pop = pass_pop + POP_W'(pass_nxt[i]);
      fail_pop = fail_pop + POP_W'(fail_nxt[i]);
    end
  end

  // Sum in a wider word so saturation is a simple compare, never a wrap.
  assign pass_sum     = {{POP_W{1'b0}}, pass_cnt} + {{CNT_W{1'b0}}, pass_pop};
  assign fail_sum     = {{POP_W{1'b0}}, fail_cnt} + {{CNT_W{1'b0}}, fail_pop};
  assign pass_cnt_nxt = (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
  assign fail_cnt_nxt = (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        d[i]     <= '0;
        lat[i]   <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nxt[i];
        d[i]     <= d_nxt[i];
        lat[i]   <= lat_nxt[i];
      end
    end
  end

  // Pulses are forced low on disabled edges; everything else simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      ack_q     <= '0;
      pass_o    <= '0;
      fail_o    <= '0;
      early_o   <= '0;
      overlap_o <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      pass_o    <= en ? pass_nxt    : '0;
      fail_o    <= en ? fail_nxt    : '0;
      early_o   <= en ? early_nxt   : '0;
      overlap_o <= en ? overlap_nxt : '0;
      if (en) begin
        req_q    <= req;
        ack_q    <= ack;
        pass_cnt <= pass_cnt_nxt;
        fail_cnt <= fail_cnt_nxt;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy_o[i]                = (state[i] == WAIT);
      lat_o[i*DLY_W +: DLY_W]  = lat[i];
    end
  end

endmodule

// File: tb/tb_req_ack_window_checker.sv
// Bench for req_ack_window_checker: table of single-check vectors plus hand-written
// overlap, multi-channel, reset and enable sequences, all scored through a queue.
module tb_req_ack_window_checker;

  localparam int NUM_CH  = 4;
  localparam int MAX_DLY = 6;
  localparam int DLY_W   = 3;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ack;

  logic [NUM_CH-1:0]       pass_o, fail_o, early_o, overlap_o, busy_o;
  logic [NUM_CH*DLY_W-1:0] lat_o;
  logic [7:0]              pass_cnt, fail_cnt;

  logic [NUM_CH-1:0]       nr_pass_o, nr_fail_o, nr_early_o, nr_overlap_o, nr_busy_o;
  logic [NUM_CH*DLY_W-1:0] nr_lat_o;
  logic [7:0]              nr_pass_cnt, nr_fail_cnt;

  logic [NUM_CH-1:0]       c2_pass_o, c2_fail_o, c2_early_o, c2_overlap_o, c2_busy_o;
  logic [NUM_CH*DLY_W-1:0] c2_lat_o;
  logic [1:0]              c2_pass_cnt, c2_fail_cnt;

  req_ack_window_checker dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .pass_o(pass_o), .fail_o(fail_o), .early_o(early_o), .overlap_o(overlap_o),
    .busy_o(busy_o), .lat_o(lat_o), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  req_ack_window_checker #(.RESTART_ON_REQ(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .pass_o(nr_pass_o), .fail_o(nr_fail_o), .early_o(nr_early_o), .overlap_o(nr_overlap_o),
    .busy_o(nr_busy_o), .lat_o(nr_lat_o), .pass_cnt(nr_pass_cnt), .fail_cnt(nr_fail_cnt)
  );

  req_ack_window_checker #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .pass_o(c2_pass_o), .fail_o(c2_fail_o), .early_o(c2_early_o), .overlap_o(c2_overlap_o),
    .busy_o(c2_busy_o), .lat_o(c2_lat_o), .pass_cnt(c2_pass_cnt), .fail_cnt(c2_fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_CH-1:0] pass_m;
    logic [NUM_CH-1:0] fail_m;
    logic [NUM_CH-1:0] early_m;
    logic [DLY_W-1:0]  lat;
    int                cyc;
  } exp_t;

  typedef struct {
    int ch;
    int ack_off;
    bit exp_pass;
    bit exp_early;
    int lat;
    int v_off;
  } vec_t;

  exp_t expq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int exp_pass_tot = 0;
  int exp_fail_tot = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void pushExp(input logic [NUM_CH-1:0] pm, input logic [NUM_CH-1:0] fm,
                                  input logic [NUM_CH-1:0] em, input logic [DLY_W-1:0] l,
                                  input int c);
    exp_t t;
    t.pass_m  = pm;
    t.fail_m  = fm;
    t.early_m = em;
    t.lat     = l;
    t.cyc     = c;
    expq.push_back(t);
  endfunction

  // Every verdict pulse from the default instance must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ((pass_o | fail_o) != '0)) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_verdict", 32'(pass_o | fail_o), 32'd0);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("verdict_cycle", cyc, mon_e.cyc);
        checkOutput("pass_o", 32'(pass_o), 32'(mon_e.pass_m));
        checkOutput("fail_o", 32'(fail_o), 32'(mon_e.fail_m));
        checkOutput("early_o", 32'(early_o), 32'(mon_e.early_m));
        for (int c = 0; c < NUM_CH; c++) begin
          if (mon_e.pass_m[c] || mon_e.fail_m[c]) begin
            checkOutput("lat_o", 32'(lat_o[c*DLY_W +: DLY_W]), 32'(mon_e.lat));
          end
        end
      end
    end
  end

  task automatic drainCheck();
    @(negedge clk);
    req = '0;
    ack = '0;
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", expq.size(), 0);
    expq.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    int base;
    logic [NUM_CH-1:0] m;
    m = NUM_CH'(1) << v.ch;
    @(negedge clk);
    base = cyc;
    pushExp(v.exp_pass ? m : '0, v.exp_pass ? '0 : m, (!v.exp_pass && v.exp_early) ? m : '0,
            DLY_W'(v.lat), base + 1 + v.v_off);
    req[v.ch] = 1'b1;
    if (v.ack_off == 0) ack[v.ch] = 1'b1;
    for (int i = 1; i <= MAX_DLY + 2; i++) begin
      @(negedge clk);
      if (v.ack_off == i) ack[v.ch] = 1'b1;
    end
    drainCheck();
  endtask

  vec_t tbl[9];

  initial begin
    int base;
    tbl[0] = '{ch: 0, ack_off:  4, exp_pass: 1, exp_early: 0, lat: 4, v_off: 4};
    tbl[1] = '{ch: 0, ack_off:  2, exp_pass: 0, exp_early: 1, lat: 2, v_off: 2};
    tbl[2] = '{ch: 0, ack_off: -1, exp_pass: 0, exp_early: 0, lat: 2, v_off: 6};
    tbl[3] = '{ch: 0, ack_off:  3, exp_pass: 1, exp_early: 0, lat: 3, v_off: 3};
    tbl[4] = '{ch: 0, ack_off:  6, exp_pass: 1, exp_early: 0, lat: 6, v_off: 6};
    tbl[5] = '{ch: 1, ack_off:  1, exp_pass: 0, exp_early: 1, lat: 1, v_off: 1};
    tbl[6] = '{ch: 2, ack_off:  0, exp_pass: 0, exp_early: 0, lat: 0, v_off: 6};
    tbl[7] = '{ch: 3, ack_off:  5, exp_pass: 1, exp_early: 0, lat: 5, v_off: 5};
    tbl[8] = '{ch: 1, ack_off:  7, exp_pass: 0, exp_early: 0, lat: 1, v_off: 6};

    rst = 1'b1;
    en  = 1'b1;
    req = '0;
    ack = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_pulses", 32'(pass_o | fail_o | early_o | overlap_o), 32'd0);
    checkOutput("reset_lat", 32'(lat_o), 32'd0);
    checkOutput("reset_cnt", {pass_cnt, fail_cnt}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      applyStimulus(tbl[k]);
      if (tbl[k].exp_pass) exp_pass_tot++;
      else exp_fail_tot++;
      checkOutput("pass_cnt", 32'(pass_cnt), exp_pass_tot);
      checkOutput("fail_cnt", 32'(fail_cnt), exp_fail_tot);
      checkOutput("c2_pass_cnt_sat", 32'(c2_pass_cnt), (exp_pass_tot > 3) ? 3 : exp_pass_tot);
      checkOutput("c2_fail_cnt_sat", 32'(c2_fail_cnt), (exp_fail_tot > 3) ? 3 : exp_fail_tot);
    end

    // Overlap with restart: re-rise at offset 2, ack four cycles after the restart.
    @(negedge clk);
    base = cyc;
    pushExp(4'b0001, '0, '0, 3'd4, base + 7);
    req[0] = 1'b1;
    for (int i = 1; i <= MAX_DLY + 2; i++) begin
      @(negedge clk);
      if (i == 1) req[0] = 1'b0;
      if (i == 2) req[0] = 1'b1;
      if (i == 3) begin
        checkOutput("overlap_restart", 32'(overlap_o[0]), 32'd1);
        checkOutput("overlap_norestart", 32'(nr_overlap_o[0]), 32'd1);
        checkOutput("busy_during_overlap", 32'(busy_o[0]), 32'd1);
      end
      if (i == 6) ack[0] = 1'b1;
    end
    drainCheck();
    exp_pass_tot++;

    // Same overlap, ack later: restarting instance passes, the other times out.
    @(negedge clk);
    base = cyc;
    pushExp(4'b0001, '0, '0, 3'd5, base + 8);
    req[0] = 1'b1;
    for (int i = 1; i <= MAX_DLY + 3; i++) begin
      @(negedge clk);
      if (i == 1) req[0] = 1'b0;
      if (i == 2) req[0] = 1'b1;
      if (i == 7) begin
        ack[0] = 1'b1;
        checkOutput("nr_timeout_fail", 32'(nr_fail_o[0]), 32'd1);
        checkOutput("nr_timeout_early", 32'(nr_early_o[0]), 32'd0);
        checkOutput("nr_timeout_lat", 32'(nr_lat_o[0 +: DLY_W]), 32'd6);
      end
    end
    drainCheck();
    exp_pass_tot++;

    // All four channels pass on one edge.
    @(negedge clk);
    base = cyc;
    pushExp(4'b1111, '0, '0, 3'd4, base + 5);
    req = 4'b1111;
    for (int i = 1; i <= MAX_DLY; i++) begin
      @(negedge clk);
      if (i == 4) ack = 4'b1111;
    end
    drainCheck();
    exp_pass_tot += 4;
    checkOutput("pass_cnt_plus4", 32'(pass_cnt), exp_pass_tot);
    checkOutput("fail_cnt_hold", 32'(fail_cnt), exp_fail_tot);
    checkOutput("c2_pass_cnt_stuck", 32'(c2_pass_cnt), 32'd3);

    // Asynchronous reset mid-check discards it.
    @(negedge clk);
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("busy_before_reset", 32'(busy_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_busy", 32'(busy_o), 32'd0);
    checkOutput("async_reset_cnt", {pass_cnt, fail_cnt}, 32'd0);
    checkOutput("async_reset_lat", 32'(lat_o), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (MAX_DLY + 2) @(negedge clk);
    checkOutput("no_verdict_after_reset", 32'(pass_cnt + fail_cnt), 32'd0);
    exp_pass_tot = 0;
    exp_fail_tot = 0;

    // Enable low for three edges mid-check delays the verdict by three cycles.
    @(negedge clk);
    base = cyc;
    pushExp(4'b0010, '0, '0, 3'd4, base + 8);
    req[1] = 1'b1;
    for (int i = 1; i <= MAX_DLY + 3; i++) begin
      @(negedge clk);
      if (i == 1) en = 1'b0;
      if (i == 4) begin
        checkOutput("busy_frozen", 32'(busy_o[1]), 32'd1);
        en = 1'b1;
      end
      if (i == 7) ack[1] = 1'b1;
    end
    drainCheck();
    exp_pass_tot++;
    checkOutput("pass_cnt_after_freeze", 32'(pass_cnt), exp_pass_tot);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
